// File: rtl/sha_const.sv
// sha_const: shared encodings for the sha_512 message sequencer
package sha_const;
  typedef enum logic [2:0] {IDLE, FILL, PAD, HASH, WAIT, DONE} ctrl_state_e;
  localparam logic [1:0] OP_224 = 2'd0;
  localparam logic [1:0] OP_256 = 2'd1;
  localparam logic [1:0] OP_384 = 2'd2;
  localparam logic [1:0] OP_512 = 2'd3;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  function automatic logic [511:0] trunc_digest(input logic [511:0] h, input logic [1:0] op);
    logic [9:0] keep;
    keep = (op == OP_224) ? 10'd224 : (op == OP_256) ? 10'd256 : (op == OP_384) ? 10'd384 : 10'd512;
    return h & ~({512{1'b1}} >> keep);
  endfunction
endpackage

// File: rtl/sha_512_pad.sv
// sha_512_pad: keep the leading n bytes of the final word and append the 0x80 marker
module sha_512_pad
  import sha_const::*;
(
  input  logic [63:0] word,
  input  logic [3:0]  n,
  output logic [63:0] pad_word,
  output logic [3:0]  n_clip
);
  assign n_clip = (n > 4'd8) ? 4'd8 : n;
  for (genvar i = 0; i < 8; i++) begin : g_byte
    assign pad_word[63-8*i -: 8] = (4'(i) < n_clip) ? word[63-8*i -: 8] :
                                   (4'(i) == n_clip) ? PAD_BYTE : 8'h00;
  end
endmodule

// File: rtl/sha_512_ctrl.sv
// sha_512_ctrl: streams a byte-aligned message into padded 1024-bit blocks for one sha_512 core
module sha_512_ctrl
  import sha_const::*;
#(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [63:0]   s_data,
  input  logic          s_valid,
  input  logic          s_last,
  input  logic [3:0]    s_bytes,
  output logic          s_ready,
  output logic [1023:0] core_data,
  output logic [127:0]  core_index,
  output logic [1:0]    core_op,
  output logic          core_en,
  input  logic [511:0]  core_hash,
  input  logic          core_rdy,
  output logic [511:0]  digest,
  output logic          digest_valid,
  output logic          busy
);
  ctrl_state_e        state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [4:0]         wp_q, wp_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [127:0]       blk_q, blk_d;
  logic [15:0][63:0]  data_q, data_d;
  logic               placed_q, placed_d, last_q, last_d, final_q, final_d;
  logic [511:0]       digest_q, digest_d;
  logic [63:0]        pad_word;
  logic [3:0]         n_clip;
  logic [127:0]       len_ext;
  sha_512_pad u_pad (.word(s_data), .n(s_bytes), .pad_word(pad_word), .n_clip(n_clip));
  assign len_ext      = 128'(len_q);
  assign s_ready      = state_q == FILL;
  assign core_en      = state_q == HASH;
  assign digest_valid = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign core_data    = data_q;
  assign core_index   = blk_q;
  assign core_op      = op_q;
  assign digest       = digest_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wp_d     = wp_q;
    len_d    = len_q;
    blk_d    = blk_q;
    data_d   = data_q;
    placed_d = placed_q;
    last_d   = last_q;
    final_d  = final_q;
    digest_d = digest_q;
    case (state_q)
      IDLE: if (start) begin
        op_d     = op;
        wp_d     = '0;
        len_d    = '0;
        blk_d    = 128'd1;
        data_d   = '0;
        placed_d = 1'b0;
        last_d   = 1'b0;
        final_d  = 1'b0;
        state_d  = FILL;
      end
      FILL: if (s_valid) begin
        data_d[wp_q[3:0]] = s_last ? pad_word : s_data;
        wp_d     = wp_q + 5'd1;
        len_d    = len_q + (s_last ? LEN_W'({n_clip, 3'b000}) : LEN_W'(64));
        last_d   = s_last;
        placed_d = s_last && (n_clip < 4'd8);
        state_d  = s_last ? PAD : (wp_q == 5'd15) ? HASH : FILL;
      end
      // one step per cycle: place the marker word, then either close with the length or spill
      PAD: if (!placed_q && !wp_q[4]) begin
        data_d[wp_q[3:0]] = {PAD_BYTE, 56'd0};
        wp_d     = wp_q + 5'd1;
        placed_d = 1'b1;
      end else begin
        if (wp_q <= 5'd14) begin
          data_d[14] = len_ext[127:64];
          data_d[15] = len_ext[63:0];
        end
        final_d = wp_q <= 5'd14;
        state_d = HASH;
      end
      HASH: state_d = WAIT;
      WAIT: if (core_rdy) begin
        blk_d    = blk_q + 128'd1;
        data_d   = '0;
        wp_d     = '0;
        digest_d = final_q ? trunc_digest(core_hash, op_q) : digest_q;
        state_d  = final_q ? DONE : last_q ? PAD : FILL;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      wp_q     <= '0;
      len_q    <= '0;
      blk_q    <= '0;
      data_q   <= '0;
      placed_q <= 1'b0;
      last_q   <= 1'b0;
      final_q  <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wp_q     <= wp_d;
      len_q    <= len_d;
      blk_q    <= blk_d;
      data_q   <= data_d;
      placed_q <= placed_d;
      last_q   <= last_d;
      final_q  <= final_d;
      digest_q <= digest_d;
    end
  end
endmodule

// File: tb/tb_sha_512_ctrl.sv
// tb_sha_512_ctrl: sha_512_ctrl driven against a behavioural sha_512 core, digests checked from a scoreboard
module tb_sha_512_ctrl;
  logic          clk = 0, rst = 0, start = 0, s_valid = 0, s_last = 0;
  logic [1:0]    op = 0;
  logic [63:0]   s_data = 0;
  logic [3:0]    s_bytes = 0;
  logic          s_ready, core_en, core_rdy, digest_valid, busy;
  logic [1023:0] core_data;
  logic [127:0]  core_index;
  logic [1:0]    core_op;
  logic [511:0]  core_hash, digest;
  int            n_cmp = 0, n_bad = 0, en_cnt = 0, unstable = 0;
  logic [127:0]  idx_q[$];
  logic [511:0]  exp_q[$];

  always #5 clk = ~clk;

  sha_512_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_bytes(s_bytes), .s_ready(s_ready), .core_data(core_data),
    .core_index(core_index), .core_op(core_op), .core_en(core_en), .core_hash(core_hash),
    .core_rdy(core_rdy), .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] iv(input logic [1:0] o);
    case (o)
      2'd0: return {64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
                    64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
      2'd1: return {64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
                    64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
      2'd2: return {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
      default: return {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                       64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    endcase
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] dw);
    logic [63:0] w [80];
    logic [63:0] a, b, c, x, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = dw[i*64 +: 64];
    for (int i = 16; i < 80; i++)
      w[i] = w[i-16] + (ror(w[i-15], 1) ^ ror(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-7] +
             (ror(w[i-2], 19) ^ ror(w[i-2], 61) ^ (w[i-2] >> 6));
    {a, b, c, x, e, f, g, h} = hin;
    for (int i = 0; i < 80; i++) begin
      t1 = h + (ror(e, 14) ^ ror(e, 18) ^ ror(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 28) ^ ror(a, 34) ^ ror(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = x + t1; x = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + x,
            hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + h};
  endfunction

  // reference digest: byte-level padding done in software, independent of the word datapath
  function automatic logic [511:0] sha_msg(input logic [7:0] m[$], input logic [1:0] o);
    logic [7:0] p[$];
    logic [127:0] lb;
    logic [511:0] h;
    logic [1023:0] d;
    int keep;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    lb = 128'(m.size()) << 3;
    for (int k = 15; k >= 0; k--) p.push_back(lb[8*k +: 8]);
    h = iv(o);
    for (int bk = 0; bk < p.size() / 128; bk++) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 8; j++) d[i*64 + 56 - 8*j +: 8] = p[bk*128 + i*8 + j];
      h = compress(h, d);
    end
    keep = (o == 2'd0) ? 224 : (o == 2'd1) ? 256 : (o == 2'd2) ? 384 : 512;
    for (int i = 0; i < 512 - keep; i++) h[i] = 1'b0;
    return h;
  endfunction

  // behavioural core: random latency, hash valid only in the Ready cycle
  logic [511:0]  chain, res;
  logic [1023:0] held;
  int            pend = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend = 0;
      core_rdy <= 1'b0;
      core_hash <= '0;
    end else begin
      core_rdy <= 1'b0;
      core_hash <= {8{64'hdeadbeef0badf00d}};
      if (core_en) begin
        en_cnt++;
        idx_q.push_back(core_index);
        held = core_data;
        res = compress((core_index == 128'd1) ? iv(core_op) : chain, core_data);
        pend = $urandom_range(6, 30);
      end else if (pend > 0) begin
        if (core_data !== held) unstable++;
        pend--;
        if (pend == 0) begin
          core_rdy <= 1'b1;
          core_hash <= res;
          chain = res;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic send(input logic [7:0] m[$], input logic [1:0] o, input int gap, input logic [3:0] sb_over);
    int nw, guard;
    logic acc;
    nw = (m.size() + 7) / 8;
    if (nw == 0) nw = 1;
    en_cnt = 0;
    idx_q.delete();
    start = 1'b1;
    op = o;
    tick();
    start = 1'b0;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++) s_data[63-8*j -: 8] = (w*8 + j < m.size()) ? m[w*8 + j] : 8'($urandom);
      s_last = (w == nw - 1);
      s_bytes = s_last ? ((sb_over != 4'd0) ? sb_over : 4'(m.size() - 8*w)) : 4'($urandom_range(0, 15));
      guard = 0;
      do begin
        s_valid = ($urandom_range(0, 99) >= gap);
        acc = s_valid && s_ready;
        tick();
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: beat %0d not accepted, required acceptance", w);
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_en(input int n);
    int guard;
    guard = 0;
    while (en_cnt < n && guard < 500) begin
      tick();
      guard++;
    end
    check("core_en_seen", 512'(en_cnt >= n), 512'(1));
  endtask

  task automatic wait_digest(input string tag, input int blocks);
    int guard;
    logic seq_ok;
    logic [511:0] want;
    guard = 0;
    while (!digest_valid && guard < 3000) begin
      tick();
      guard++;
    end
    if (!digest_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: digest_valid 0, required 1", tag);
      exp_q.delete();
      return;
    end
    want = exp_q.pop_front();
    check({tag, "_digest"}, digest, want);
    check({tag, "_blocks"}, 512'(en_cnt), 512'(blocks));
    seq_ok = 1'b1;
    foreach (idx_q[k]) if (idx_q[k] !== 128'(k + 1)) seq_ok = 1'b0;
    check({tag, "_index_seq"}, 512'(seq_ok), 512'(1));
    tick();
    check({tag, "_pulse_end"}, {digest_valid, busy}, 0);
    check({tag, "_held"}, digest, want);
  endtask

  initial begin
    logic [7:0] abc[$], nil[$], alpha[$], rnd[$];
    int lens[6] = '{116, 120, 128, 136, 111, 119};
    abc = {8'h61, 8'h62, 8'h63};
    for (int g = 0; g < 14; g++)
      for (int j = 0; j < 8; j++) alpha.push_back(8'(8'h61 + g + j));
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_core_en", core_en, 0);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digest", digest, 0);
    check("rst_core_data", 512'(|core_data), 0);
    check("rst_core_index", core_index, 0);
    rst = 1'b1;
    tick();
    exp_q.push_back(512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f);
    send(abc, 2'd3, 0, 4'd0);
    wait_digest("abc_512", 1);
    exp_q.push_back({384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, 128'd0});
    send(abc, 2'd2, 0, 4'd0);
    wait_digest("abc_384", 1);
    exp_q.push_back(512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e);
    send(nil, 2'd3, 0, 4'd0);
    wait_digest("empty", 1);
    exp_q.push_back(512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909);
    send(alpha, 2'd3, 0, 4'd0);
    wait_digest("two_block", 2);
    for (int o = 0; o < 2; o++) begin
      exp_q.push_back(sha_msg(abc, 2'(o)));
      send(abc, 2'(o), 0, 4'd0);
      wait_digest($sformatf("abc_op%0d", o), 1);
    end
    foreach (lens[k]) begin
      rnd.delete();
      repeat (lens[k]) rnd.push_back(8'($urandom));
      exp_q.push_back(sha_msg(rnd, 2'd3));
      send(rnd, 2'd3, 20, 4'd0);
      wait_digest($sformatf("len%0d", lens[k]), (lens[k] + 17 + 127) / 128);
    end
    rnd.delete();
    repeat (16) rnd.push_back(8'($urandom));
    exp_q.push_back(sha_msg(rnd, 2'd1));
    send(rnd, 2'd1, 0, 4'd12);
    wait_digest("sbytes_over", 1);
    exp_q.push_back(512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909);
    send(alpha, 2'd3, 30, 4'd0);
    wait_en(1);
    tick();
    start = 1'b1;
    op = 2'd0;
    tick();
    start = 1'b0;
    check("busy_in_wait", busy, 1);
    wait_digest("start_in_wait", 2);
    send(abc, 2'd3, 0, 4'd0);
    wait_en(1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    tick();
    check("abort_next", {digest_valid, busy, core_en, s_ready}, 0);
    check("abort_digest", digest, 0);
    rst = 1'b1;
    tick();
    exp_q.push_back(512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f);
    send(abc, 2'd3, 0, 4'd0);
    wait_digest("after_reset", 1);
    check("data_stable", 512'(unstable), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
